// File: rtl/mcp_rx_multi_if.sv
// Receive-side bundle of the multi-channel toggle MCP crossing.
// master drives the tx-facing inputs; slave is the crossing itself.
interface mcp_rx_multi_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  logic [NUM_CH-1:0]       toggle_in;
  logic [NUM_CH*WIDTH-1:0] data_in;
  logic [NUM_CH*WIDTH-1:0] data_out;
  logic [NUM_CH-1:0]       data_valid;
  logic [NUM_CH-1:0]       data_ready;
  logic [NUM_CH-1:0]       load_pulse;
  logic [NUM_CH-1:0]       ack_toggle;
  logic [NUM_CH-1:0]       overflow;
  logic                    overflow_clr;

  modport master (
    output toggle_in, data_in, data_ready, overflow_clr,
    input  data_out, data_valid, load_pulse, ack_toggle, overflow
  );

  modport slave (
    input  toggle_in, data_in, data_ready, overflow_clr,
    output data_out, data_valid, load_pulse, ack_toggle, overflow
  );
endinterface

// File: rtl/mcp_rx_multi.sv
// Multi-channel toggle MCP receiver: sync, edge detect, hold, ack.
// Sticky overflow with drop/overwrite policy; sync chain primes in reset.
module mcp_rx_multi #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int OVERWRITE   = 0
) (
  input logic          clk_rx,
  input logic          rst,
  mcp_rx_multi_if.slave bus
);
  localparam bit OVR = (OVERWRITE != 0);

  logic [SYNC_STAGES-1:0]  sync_q [NUM_CH];
  logic [NUM_CH-1:0]       edge_q;
  logic [NUM_CH-1:0]       sync_top;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       consume;
  logic [NUM_CH-1:0]       ovf_set;
  logic [NUM_CH*WIDTH-1:0] data_q;
  logic [NUM_CH-1:0]       valid_q;
  logic [NUM_CH-1:0]       ack_q;
  logic [NUM_CH-1:0]       ovf_q;

  // Sync chain and edge flop run through reset so they settle on the
  // held toggle level and no stale edge appears at release.
  always_ff @(posedge clk_rx) begin
    for (int i = 0; i < NUM_CH; i++) begin
      sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.toggle_in[i]};
      edge_q[i] <= sync_q[i][SYNC_STAGES-1];
    end
  end

  // Per-channel strobes derived from the synchronised toggle.
  always_comb begin
    sync_top = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sync_top[i] = sync_q[i][SYNC_STAGES-1];
    end
    load    = (sync_top ^ edge_q) & ~{NUM_CH{rst}};
    consume = valid_q & bus.data_ready;
    ovf_set = load & valid_q & ~bus.data_ready;
  end

  // Data capture: a new word lands when the stage is free, is being
  // drained this cycle, or when the overwrite policy is selected.
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i] && (!valid_q[i] || consume[i] || OVR)) begin
          data_q[i*WIDTH +: WIDTH] <= bus.data_in[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Valid holds while a word is unconsumed; ack flips per consumed word.
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      valid_q <= '0;
      ack_q   <= '0;
    end else begin
      valid_q <= load | (valid_q & ~consume);
      ack_q   <= ack_q ^ consume;
    end
  end

  // Sticky overflow; a new set beats a simultaneous clear.
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (bus.overflow_clr) begin
      ovf_q <= ovf_set;
    end else begin
      ovf_q <= ovf_q | ovf_set;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.load_pulse = load;
  assign bus.ack_toggle = ack_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: doc/mcp_rx_multi.md
Name: mcp_rx_multi

Overview:
- Parametrised, multi-channel receive side of a toggle-based multi-cycle-path (MCP) clock-domain crossing.
- Each of NUM_CH channels takes an asynchronous toggle flag and a data bus that the transmit domain holds stable.
- Per channel, the block synchronises the toggle, captures the word into a valid/ready output stage, and returns an acknowledge toggle on consumption for feedback MCP.
- Adds sticky per-channel overflow detection, a selectable drop/overwrite policy, and glitch-free synchroniser priming during reset.
- The block lives entirely in the receive clock domain.

Parameters:
- NUM_CH, 4: number of independent channels, ≥1.
- WIDTH, 8: data bits per channel, ≥1.
- SYNC_STAGES, 2: synchroniser flops ahead of the edge-detect flop, ≥2.
- OVERWRITE, 0: policy when a word arrives while the previous word is still unconsumed. 0 = drop the new word. 1 = replace the held word with the new one.

Ports:
- clk_rx  in  1  receive-domain clock.
- rst  in  1  synchronous, active-high reset.
- toggle_in  in  NUM_CH  per-channel toggle flag from the tx domain; asynchronous.
- data_in  in  NUM_CH*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH]. Held stable by tx until acknowledged.
- data_out  out  NUM_CH*WIDTH  captured data, same packing as data_in.
- data_valid  out  NUM_CH  data_out for channel i holds an unconsumed word.
- data_ready  in  NUM_CH  downstream accepts channel i this cycle.
- load_pulse  out  NUM_CH  one-cycle strobe: synchronised toggle edge detected.
- ack_toggle  out  NUM_CH  flips once per consumed word; returned to the tx domain.
- overflow  out  NUM_CH  sticky: a word arrived while the previous one was unconsumed.
- overflow_clr  in  1  clears all overflow bits.

Behaviour:
- Clock and reset: single clock, clk_rx. Reset is synchronous and active-high on rst. All channels are independent and identical.

Synchroniser, per channel:
- Chain s[1..SYNC_STAGES] followed by an edge flop e. Every cycle: s[1] <= toggle_in, s[k] <= s[k-1], e <= s[SYNC_STAGES].
- The chain and e keep shifting during rst; they are not cleared. This is reset priming.
- load_pulse = (s[SYNC_STAGES] ^ e) & ~rst.
- Latency: a toggle_in change sampled at clk_rx edge N gives load_pulse high in the cycle after edge N+SYNC_STAGES-1. The capture happens at edge N+SYNC_STAGES.
- With the default of 2, this is 3 edges from first sample to data_out update.

Reset:
- While rst=1: data_out=0, data_valid=0, ack_toggle=0, overflow=0, load_pulse=0.
- A toggle_in value held stable for ≥ SYNC_STAGES+1 cycles of rst produces no load_pulse after release.
- A toggle_in change during the final SYNC_STAGES cycles of rst produces exactly one load_pulse after release.
- rst asserted mid-transfer discards the held word and forces valid low next cycle.

Output stage, per channel:
- consume = data_valid & data_ready.
- load_pulse & ~data_valid: data_out <= data_in, data_valid <= 1.
- load_pulse & consume: data_out <= data_in, data_valid stays 1, ack_toggle flips. This is the simultaneous-event case.
- load_pulse & data_valid & ~data_ready:
  - overflow <= 1.
  - OVERWRITE=0: data_out unchanged.
  - OVERWRITE=1: data_out <= data_in.
  - ack_toggle does not flip in either case.
- consume & ~load_pulse: data_valid <= 0, ack_toggle flips.
- data_ready while ~data_valid has no effect.

Overflow clear:
- overflow_clr clears every overflow bit.
- If a set condition and overflow_clr occur in the same cycle, set wins.

General:
- All outputs are registered except load_pulse.
- No width arithmetic: data passes through unmodified.
- The block assumes the tx side waits for the ack before changing data_in. Data changing within SYNC_STAGES+1 cycles before capture is a protocol violation, and the captured value is undefined.

Test Plan:
- Reset priming: hold toggle_in=4'b1010 and rst=1 for 10 cycles, then release. Required: load_pulse=0 for 20 cycles after release; data_valid=0; overflow=0.
- Basic transfer (ch0): set data_in[7:0]=8'hA5, then flip toggle_in[0] at edge N, with data_ready=1. Required: load_pulse[0] high exactly one cycle; data_out[7:0]=8'hA5 and data_valid[0]=1 after edge N+2; data_valid clears and ack_toggle[0]=1 one cycle later.
- Backpressure drop (OVERWRITE=0): hold data_ready[1]=0. Send 8'h11, then 8'h22 on ch1. Required: data_out=8'h11, overflow[1]=1, ack_toggle[1] still 0. After raising data_ready: one consume, ack_toggle[1]=1. Repeat with OVERWRITE=1: data_out=8'h22, overflow[1]=1.
- Simultaneous load and consume (ch2): word 8'h33 valid; raise data_ready in the cycle load_pulse[2] is high for 8'h44. Required: data_out=8'h44, data_valid stays 1, ack_toggle[2] flips once, overflow[2]=0.
- Overflow clear race: assert overflow_clr in the same cycle as a new overflow on ch3. Required: overflow[3]=1. Assert overflow_clr alone next cycle: overflow=4'b0000.
- Parametrised sweep at NUM_CH=1, WIDTH=32, SYNC_STAGES=3: toggle at edge N. Required: capture at edge N+3, and 32'hDEADBEEF is passed intact.
